// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, WAIT_STATES of latency, RV32I sizing.
// Optional build macro DMEM_ERR_EN turns on access-error reporting; otherwise rsp_err is constant 0.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic          accept, commit, mem_we;
    logic          a_we, a_err;
    logic [31:0]   a_addr, a_wdata;
    logic [2:0]    a_f3;
    size_e         a_size;
    logic [1:0]    a_lane;
    logic [AW-1:0] a_idx;
    logic [31:0]   cur_word, wr_word, ld_data;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    assign accept = (state_q == S_IDLE) && req_valid;

    // With zero wait states the access commits on the accept edge, so it must see the live request.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        a_we    = accept ? req_we     : we_q;
        a_addr  = accept ? req_addr   : addr_q;
        a_wdata = accept ? req_wdata  : wdata_q;
        a_f3    = accept ? req_funct3 : f3_q;

        case (a_f3)
            3'd0:    a_size = SZ_B;
            3'd1:    a_size = SZ_H;
            3'd4:    a_size = a_we ? SZ_W : SZ_B;
            3'd5:    a_size = a_we ? SZ_W : SZ_H;
            default: a_size = SZ_W;
        endcase

        case (a_size)
            SZ_B:    a_lane = a_addr[1:0];
            SZ_H:    a_lane = {a_addr[1], 1'b0};
            default: a_lane = 2'b00;
        endcase

        a_idx = a_addr[AW+1:2];
        a_err = 1'b0;
`ifdef DMEM_ERR_EN
        a_err = ({1'b0, a_addr} >= 33'(DEPTH) * 33'd4)
              || ((a_size == SZ_H) && a_addr[0])
              || ((a_size == SZ_W) && (a_addr[1:0] != 2'b00))
              || (a_we ? (a_f3 > 3'd2) : (a_f3 == 3'd3 || a_f3 == 3'd6 || a_f3 == 3'd7));
`endif

        cur_word = mem[a_idx];
        wr_word  = cur_word;
        case (a_size)
            SZ_B:    wr_word[{a_lane, 3'b000} +: 8] = a_wdata[7:0];
            SZ_H:    wr_word = a_lane[1] ? {a_wdata[15:0], cur_word[15:0]}
                                         : {cur_word[31:16], a_wdata[15:0]};
            default: wr_word = a_wdata;
        endcase

        ld_byte = 8'(cur_word >> {a_lane, 3'b000});
        ld_half = a_lane[1] ? cur_word[31:16] : cur_word[15:0];
        case (a_size)
            SZ_B:    ld_data = a_f3[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = a_f3[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = cur_word;
        endcase
    end

`ifndef DMEM_ERR_EN
    logic unused_addr_bits;
    assign unused_addr_bits = ^{a_addr[31:AW+2], a_addr[0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    f3_d    = req_funct3;
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            err_d   = a_err;
            rdata_d = (a_err || a_we) ? 32'd0 : ld_data;
        end
    end

    assign mem_we = commit && a_we && !a_err;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the array has no reset so it maps onto plain RAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) mem[a_idx] <= wr_word;
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 with WAIT_STATES=2, instance 1 with WAIT_STATES=0.
// Expectations follow DMEM_ERR_EN when the bench is built with that macro.
module tb_dmem_responder;
`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [2:0]  req_funct3 [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    dmem_responder #(.DEPTH(256), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction; hold>0 keeps rsp_ready low for that many RESP cycles while
    // a competing store request is presented and must be ignored.
    task automatic xact(input string tag, input int u, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input int hold);
        int n, lat, busy;
        @(negedge clk);
        req_valid[u]  = 1'b1;
        req_we[u]     = we;
        req_addr[u]   = addr;
        req_wdata[u]  = wdata;
        req_funct3[u] = f3;
        rsp_ready[u]  = (hold == 0);
        n = 0;
        while (!req_ready[u] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, 32'(req_ready[u]), 32'd1);
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        req_valid[u] = 1'b0;
        lat  = 1;
        busy = 0;
        while (!rsp_valid[u] && lat < 40) begin
            if (req_ready[u]) busy++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (req_ready[u]) busy++;
        check({tag, "_lat"},   32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, rsp_rdata[u], exp_rdata);
        check({tag, "_err"},   32'(rsp_err[u]), 32'(exp_err));
        check({tag, "_busy"},  32'(busy), 32'd0);
        for (int i = 0; i < hold; i++) begin
            req_valid[u]  = 1'b1;
            req_we[u]     = 1'b1;
            req_addr[u]   = addr;
            req_wdata[u]  = 32'h0;
            req_funct3[u] = 3'd2;
            @(posedge clk);
            #1;
            check({tag, "_stall_valid"}, 32'(rsp_valid[u]), 32'd1);
            check({tag, "_stall_rdata"}, rsp_rdata[u], exp_rdata);
            check({tag, "_stall_ready"}, 32'(req_ready[u]), 32'd0);
        end
        req_valid[u] = 1'b0;
        rsp_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_idle"}, 32'(req_ready[u]), 32'd1);
        check({tag, "_rsp_drop"}, 32'(rsp_valid[u]), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t ws0_vec [4];
        int   prev_acc;

        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = 32'h0;
            req_wdata[u] = 32'h0; req_funct3[u] = 3'd0; rsp_ready[u] = 1'b1;
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",  32'(req_ready[0]), 32'd1);
        check("rst_valid",  32'(rsp_valid[0]), 32'd0);
        check("rst_rdata",  rsp_rdata[0], 32'h0);
        check("rst_err",    32'(rsp_err[0]), 32'd0);
        check("rst_ready1", 32'(req_ready[1]), 32'd1);
        check("rst_valid1", 32'(rsp_valid[1]), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // basic word store/load with two wait states
        xact("sw10", 0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0,        1'b0, 3, 0);
        xact("lw10", 0, 1'b0, 32'h10, 32'h0,        3'd2, 32'hDEADBEEF, 1'b0, 3, 0);

        // byte store and sized loads
        xact("sb13",  0, 1'b1, 32'h13, 32'h00000080, 3'd0, 32'h0,        1'b0, 3, 0);
        xact("lb13",  0, 1'b0, 32'h13, 32'h0,        3'd0, 32'hFFFFFF80, 1'b0, 3, 0);
        xact("lbu13", 0, 1'b0, 32'h13, 32'h0,        3'd4, 32'h00000080, 1'b0, 3, 0);
        xact("lw10b", 0, 1'b0, 32'h10, 32'h0,        3'd2, 32'h80ADBEEF, 1'b0, 3, 0);
        xact("lh12",  0, 1'b0, 32'h12, 32'h0,        3'd1, 32'hFFFF80AD, 1'b0, 3, 0);
        xact("lhu12", 0, 1'b0, 32'h12, 32'h0,        3'd5, 32'h000080AD, 1'b0, 3, 0);
        xact("sh10",  0, 1'b1, 32'h30, 32'hAAAA1234, 3'd1, 32'h0,        1'b0, 3, 0);
        xact("sh32",  0, 1'b1, 32'h32, 32'hBBBB5678, 3'd1, 32'h0,        1'b0, 3, 0);
        xact("lw30",  0, 1'b0, 32'h30, 32'h0,        3'd2, 32'h56781234, 1'b0, 3, 0);

        // back-pressure: response held five cycles, competing store ignored
        xact("stall", 0, 1'b0, 32'h10, 32'h0, 3'd2, 32'h80ADBEEF, 1'b0, 3, 5);
        xact("lw10c", 0, 1'b0, 32'h10, 32'h0, 3'd2, 32'h80ADBEEF, 1'b0, 3, 0);

        // misaligned, illegal and out-of-range accesses
        xact("sw0",    0, 1'b1, 32'h0,   32'hCAFEF00D, 3'd2, 32'h0, 1'b0, 3, 0);
        xact("lw12",   0, 1'b0, 32'h12,  32'h0, 3'd2, ERR_EN ? 32'h0 : 32'h80ADBEEF, ERR_EN, 3, 0);
        xact("lh11",   0, 1'b0, 32'h11,  32'h0, 3'd1, ERR_EN ? 32'h0 : 32'hFFFFBEEF, ERR_EN, 3, 0);
        xact("lf3_3",  0, 1'b0, 32'h10,  32'h0, 3'd3, ERR_EN ? 32'h0 : 32'h80ADBEEF, ERR_EN, 3, 0);
        xact("sw400",  0, 1'b1, 32'h400, 32'h1, 3'd2, 32'h0, ERR_EN, 3, 0);
        xact("lw0",    0, 1'b0, 32'h0,   32'h0, 3'd2, ERR_EN ? 32'hCAFEF00D : 32'h00000001, 1'b0, 3, 0);

        // reset in the first WAIT cycle drops the store
        xact("sw20a", 0, 1'b1, 32'h20, 32'h0, 3'd2, 32'h0, 1'b0, 3, 0);
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20;
        req_wdata[0] = 32'h12345678; req_funct3[0] = 3'd2;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        check("mid_wait_busy", 32'(req_ready[0]), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid[0]), 32'd0);
        check("mid_rst_ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_valid", 32'(rsp_valid[0]), 32'd0);
        xact("lw20", 0, 1'b0, 32'h20, 32'h0, 3'd2, 32'h00000000, 1'b0, 3, 0);

        // zero wait states: one request every two cycles
        ws0_vec[0] = '{1'b1, 32'h40, 32'h11111111, 32'h0};
        ws0_vec[1] = '{1'b0, 32'h40, 32'h0,        32'h11111111};
        ws0_vec[2] = '{1'b1, 32'h44, 32'h22223333, 32'h0};
        ws0_vec[3] = '{1'b0, 32'h44, 32'h0,        32'h22223333};
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            xact("ws0", 1, ws0_vec[i].we, ws0_vec[i].addr, ws0_vec[i].wdata, 3'd2,
                 ws0_vec[i].exp, 1'b0, 1, 0);
            if (i > 0) check("ws0_spacing", 32'(acc_cyc - prev_acc), 32'd2);
            prev_acc = acc_cyc;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
